// File: rtl/lc3_pkg.sv
// Shared opcode constants, memory-state encoding and instruction field helpers
// for the LC-3 pipeline controller.
package lc3_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   typedef enum logic [1:0] {
      MS_READ     = 2'd0,
      MS_WRITE    = 2'd1,
      MS_INDIRECT = 2'd2,
      MS_IDLE     = 2'd3
   } mem_state_t;

   function automatic logic [3:0] opcode(input logic [15:0] instr);
      return instr[15:12];
   endfunction

   function automatic logic [2:0] dr_field(input logic [15:0] instr);
      return instr[11:9];
   endfunction

   function automatic logic [2:0] sr1_field(input logic [15:0] instr);
      return instr[8:6];
   endfunction

   function automatic logic [2:0] sr2_field(input logic [15:0] instr);
      return instr[2:0];
   endfunction

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_BR) || (op == OP_JMP);
   endfunction

   function automatic logic writes_alu(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
   endfunction

endpackage

// File: rtl/lc3_pipe_controller_if.sv
// Handshake/status bundle between the LC-3 datapath (master) and the pipeline
// controller (slave).
interface lc3_pipe_controller_if;
   logic        complete_instr;
   logic        complete_data;
   logic [15:0] Imem_dout;
   logic [15:0] IR;
   logic [15:0] IR_Exec;
   logic [2:0]  psr;
   logic        enable_fetch;
   logic        enable_updatePC;
   logic        enable_decode;
   logic        enable_execute;
   logic        enable_writeback;
   logic        br_taken;
   logic [1:0]  mem_state;
   logic        bypass_alu_1;
   logic        bypass_alu_2;
   logic        bypass_mem_1;
   logic        bypass_mem_2;

   modport master (
      output complete_instr, complete_data, Imem_dout, IR, IR_Exec, psr,
      input  enable_fetch, enable_updatePC, enable_decode, enable_execute,
             enable_writeback, br_taken, mem_state,
             bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
   );

   modport slave (
      input  complete_instr, complete_data, Imem_dout, IR, IR_Exec, psr,
      output enable_fetch, enable_updatePC, enable_decode, enable_execute,
             enable_writeback, br_taken, mem_state,
             bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
   );
endinterface

// File: rtl/lc3_hazard_detect.sv
// Combinational RAW compare between the instruction in Memory/Writeback and the
// instruction in Execute; split by producer kind (ALU result vs. load data).
module lc3_hazard_detect
   import lc3_pkg::*;
(
   input  logic [15:0] ir,
   input  logic [15:0] ir_exec,
   output logic        alu_1,
   output logic        alu_2,
   output logic        mem_1,
   output logic        mem_2
);

   logic [3:0] exec_op;
   logic [2:0] exec_dr;
   logic       hit_1;
   logic       hit_2;
   logic       exec_alu;
   logic       exec_load;

   assign exec_op   = opcode(ir_exec);
   assign exec_dr   = dr_field(ir_exec);
   assign exec_alu  = writes_alu(exec_op);
   assign exec_load = is_load(exec_op);

   // SR2 only exists in register mode (bit 5 clear selects a register operand)
   assign hit_1 = (exec_dr == sr1_field(ir));
   assign hit_2 = !ir[5] && (exec_dr == sr2_field(ir));

   assign alu_1 = exec_alu  & hit_1;
   assign alu_2 = exec_alu  & hit_2;
   assign mem_1 = exec_load & hit_1;
   assign mem_2 = exec_load & hit_2;

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC-3 pipeline sequencer: stage enables, stalls, branch bubbles, LDI/STI memory FSM.
// Build option LC3_BYPASS_EN: forward via bypass selects instead of stalling on RAW hazards.
//
// state            | meaning
// MS_READ     (0)  | data read in flight; writeback fires on completion
// MS_WRITE    (1)  | data write in flight
// MS_INDIRECT (2)  | LDI/STI pointer fetch in flight
// MS_IDLE     (3)  | no data access; pipeline free to advance
module lc3_pipe_controller
   import lc3_pkg::*;
#(
   parameter int unsigned BR_PENALTY = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   lc3_pipe_controller_if.slave bus
);

   localparam logic [2:0] BR_CNT_INIT = 3'(BR_PENALTY);

   mem_state_t ms_q, ms_d;
   logic [2:0] br_q, br_d;
   logic [2:0] valid_q, valid_d;
   logic [1:0] haz_q, haz_d;
   logic       haz_done_q, haz_done_d;
   logic       fetch_q, fetch_d;
   logic       pc_q, pc_d;
   logic       dec_q, dec_d;
   logic       exe_q, exe_d;
   logic       wb_q, wb_d;
   logic       taken_q, taken_d;

   logic [3:0] ir_op;
   logic [3:0] dout_op;
   logic       raw_alu_1, raw_alu_2, raw_mem_1, raw_mem_2;
   logic       raw_stall;
   logic       mem_wb;
   logic       haz_trig;
   logic       br_load;

   assign ir_op   = opcode(bus.IR);
   assign dout_op = opcode(bus.Imem_dout);

   lc3_hazard_detect u_hazard (
      .ir      (bus.IR),
      .ir_exec (bus.IR_Exec),
      .alu_1   (raw_alu_1),
      .alu_2   (raw_alu_2),
      .mem_1   (raw_mem_1),
      .mem_2   (raw_mem_2)
   );

`ifdef LC3_BYPASS_EN
   assign bus.bypass_alu_1 = raw_alu_1;
   assign bus.bypass_alu_2 = raw_alu_2;
   assign bus.bypass_mem_1 = raw_mem_1;
   assign bus.bypass_mem_2 = raw_mem_2;
   assign raw_stall        = 1'b0;
`else
   assign bus.bypass_alu_1 = 1'b0;
   assign bus.bypass_alu_2 = 1'b0;
   assign bus.bypass_mem_1 = 1'b0;
   assign bus.bypass_mem_2 = 1'b0;
   assign raw_stall        = raw_alu_1 | raw_alu_2 | raw_mem_1 | raw_mem_2;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ms_q       <= MS_IDLE;
         br_q       <= '0;
         valid_q    <= '0;
         haz_q      <= '0;
         haz_done_q <= 1'b0;
         fetch_q    <= 1'b1;
         pc_q       <= 1'b1;
         dec_q      <= 1'b0;
         exe_q      <= 1'b0;
         wb_q       <= 1'b0;
         taken_q    <= 1'b0;
      end else begin
         ms_q       <= ms_d;
         br_q       <= br_d;
         valid_q    <= valid_d;
         haz_q      <= haz_d;
         haz_done_q <= haz_done_d;
         fetch_q    <= fetch_d;
         pc_q       <= pc_d;
         dec_q      <= dec_d;
         exe_q      <= exe_d;
         wb_q       <= wb_d;
         taken_q    <= taken_d;
      end
   end

   always_comb begin
      ms_d       = ms_q;
      br_d       = br_q;
      valid_d    = valid_q;
      haz_d      = haz_q;
      haz_done_d = haz_done_q;
      taken_d    = 1'b0;
      fetch_d    = 1'b0;
      pc_d       = 1'b0;
      dec_d      = 1'b0;
      exe_d      = 1'b0;

      case (ms_q)
         MS_IDLE: begin
            if (exe_q) begin
               case (ir_op)
                  OP_LD,  OP_LDR: ms_d = MS_READ;
                  OP_ST,  OP_STR: ms_d = MS_WRITE;
                  OP_LDI, OP_STI: ms_d = MS_INDIRECT;
                  default:        ms_d = MS_IDLE;
               endcase
            end
         end
         MS_INDIRECT: if (bus.complete_data) ms_d = (ir_op == OP_LDI) ? MS_READ : MS_WRITE;
         MS_READ:     if (bus.complete_data) ms_d = MS_IDLE;
         MS_WRITE:    if (bus.complete_data) ms_d = MS_IDLE;
      endcase

      mem_wb = (ms_q == MS_READ) && bus.complete_data;
      wb_d   = mem_wb;

      // A finished stall is not re-detected until Execute has advanced once
      haz_trig = raw_stall && exe_q && !haz_done_q && (haz_q == 2'd0)
                 && (ms_d == MS_IDLE) && bus.complete_instr;
      if (haz_q != 2'd0) haz_d = haz_q - 2'd1;
      else if (haz_trig) haz_d = 2'd2;
      if (haz_q == 2'd1) haz_done_d = 1'b1;
      else if (exe_q)    haz_done_d = 1'b0;

      br_load = is_branch(dout_op) && dec_q && bus.complete_instr && (ms_d == MS_IDLE)
                && !haz_trig && (br_q == 3'd0);
      if ((ms_q == MS_IDLE) && (br_q != 3'd0)) begin
         br_d = br_q - 3'd1;
         if (br_q == 3'd1)
            taken_d = (ir_op == OP_JMP) | ((ir_op == OP_BR) & (|(bus.psr & dr_field(bus.IR))));
      end else if (br_load) begin
         br_d = BR_CNT_INIT;
      end

      if ((ms_d == MS_IDLE) && bus.complete_instr) begin
         if (haz_d != 2'd0) begin
            wb_d = mem_wb | valid_q[2];
         end else begin
            valid_d = {valid_q[1:0], 1'b1};
            exe_d   = valid_d[1];
            wb_d    = valid_d[2] | mem_wb;
            if (br_d == 3'd0) begin
               fetch_d = 1'b1;
               pc_d    = 1'b1;
               dec_d   = valid_d[0];
            end
         end
      end
   end

   assign bus.enable_fetch     = fetch_q;
   assign bus.enable_updatePC  = pc_q;
   assign bus.enable_decode    = dec_q;
   assign bus.enable_execute   = exe_q;
   assign bus.enable_writeback = wb_q;
   assign bus.br_taken         = taken_q;
   assign bus.mem_state        = ms_q;

endmodule
